// File: rtl/timing_engine_fanout.sv
// rtl/timing_engine_fanout.sv - request FIFO feeding an N-channel sequential execute/dataTx fan-out
//
// Purpose: queues start/data requests in a DEPTH-entry FIFO and, for each request,
// fires the enabled channels one at a time in ascending order with a programmable gap,
// then pulses dataReady once the request has been fully dispatched.
//
// Ports:
//   clk       in   sole clock, rising edge
//   reset     in   synchronous active-high reset
//   start     in   request strobe, accepted when start && ready
//   data      in   request payload, sampled with start
//   chMask    in   channel enable mask, sampled when a request is loaded
//   gap       in   idle cycles between channel fires, sampled at each fire
//   ready     out  FIFO can accept a request (low during reset)
//   dataReady out  one-cycle pulse when the current request is fully dispatched
//   execute   out  one-hot, one-cycle fire pulse per channel
//   dataTx    out  per-channel payload lanes, held until the lane fires again
//   busy      out  engine active or requests queued
//   overrun   out  sticky flag: a start was dropped because the FIFO was full

module timing_engine_fanout #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 1,
    parameter int DEPTH  = 2,
    parameter int GAP_W  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DATA_W-1:0]        data,
    input  logic [NUM_CH-1:0]        chMask,
    input  logic [GAP_W-1:0]         gap,
    output logic                     ready,
    output logic                     dataReady,
    output logic [NUM_CH-1:0]        execute,
    output logic [NUM_CH*DATA_W-1:0] dataTx,
    output logic                     busy,
    output logic                     overrun
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FIRE,
        S_GAP,
        S_DONE
    } state_t;

    state_t state;
    state_t state_n;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] pend_n;
    logic [NUM_CH-1:0] fire_bit;
    logic [NUM_CH-1:0] fire_bit_n;
    logic [GAP_W-1:0]  cnt;
    logic [GAP_W-1:0]  cnt_n;
    logic [DATA_W-1:0] cur_data;
    logic [DATA_W-1:0] cur_data_n;

    logic push;
    logic pop;

    // ready is derived from the registered count only, so a pop in the same
    // cycle never frees a slot for that cycle's start.
    assign ready = !reset && (count != FULL_CNT);
    assign push  = start && ready;
    assign pop   = (state == S_LOAD);
    assign busy  = (state != S_IDLE) || (count != '0);

    // Lowest set bit of the pending mask is the channel fired in FIRE.
    assign fire_bit = pend & (~pend + NUM_CH'(1));

    // Next-state logic is computed ahead of the edge so that execute, dataTx and
    // dataReady can be registered yet still coincide with the FIRE/DONE state.
    always_comb begin
        state_n    = state;
        pend_n     = pend;
        cnt_n      = cnt;
        cur_data_n = cur_data;
        case (state)
            S_IDLE: begin
                if (count != '0) state_n = S_LOAD;
            end
            S_LOAD: begin
                cur_data_n = mem[rd_ptr];
                pend_n     = chMask;
                state_n    = (chMask == '0) ? S_DONE : S_FIRE;
            end
            S_FIRE: begin
                pend_n = pend & ~fire_bit;
                if (pend_n == '0) begin
                    state_n = S_DONE;
                end else if (gap == '0) begin
                    state_n = S_FIRE;
                end else begin
                    cnt_n   = gap;
                    state_n = S_GAP;
                end
            end
            S_GAP: begin
                // Leaving on cnt==1 gives exactly 'gap' idle cycles between fires.
                if (cnt == GAP_W'(1)) state_n = S_FIRE;
                else                  cnt_n   = cnt - GAP_W'(1);
            end
            S_DONE: begin
                state_n = (count != '0) ? S_LOAD : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign fire_bit_n = pend_n & (~pend_n + NUM_CH'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            pend      <= '0;
            cnt       <= '0;
            cur_data  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            execute   <= '0;
            dataTx    <= '0;
            dataReady <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            pend      <= pend_n;
            cnt       <= cnt_n;
            cur_data  <= cur_data_n;
            execute   <= (state_n == S_FIRE) ? fire_bit_n : '0;
            dataReady <= (state_n == S_DONE);

            if (state_n == S_FIRE) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (fire_bit_n[i]) dataTx[i*DATA_W +: DATA_W] <= cur_data_n;
                end
            end

            if (push) begin
                mem[wr_ptr] <= data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);

            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase

            if (start && !ready) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_timing_engine_fanout.sv
// tb/tb_timing_engine_fanout.sv - directed self-checking bench for timing_engine_fanout

module tb_timing_engine_fanout;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2;
    localparam int GAP_W  = 4;
    localparam int NCYC   = 32;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     start;
    logic [DATA_W-1:0]        data;
    logic [NUM_CH-1:0]        chMask;
    logic [GAP_W-1:0]         gap;
    logic                     ready;
    logic                     dataReady;
    logic [NUM_CH-1:0]        execute;
    logic [NUM_CH*DATA_W-1:0] dataTx;
    logic                     busy;
    logic                     overrun;

    timing_engine_fanout #(
        .NUM_CH(NUM_CH),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .GAP_W (GAP_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .data     (data),
        .chMask   (chMask),
        .gap      (gap),
        .ready    (ready),
        .dataReady(dataReady),
        .execute  (execute),
        .dataTx   (dataTx),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [NUM_CH-1:0]        ex [NCYC];
    logic                     dr [NCYC];
    logic                     bz [NCYC];
    logic                     rd [NCYC];
    logic                     ov [NCYC];
    logic [NUM_CH*DATA_W-1:0] tx [NCYC];

    task automatic sample(input int k);
        @(negedge clk);
        ex[k] = execute;
        dr[k] = dataReady;
        bz[k] = busy;
        rd[k] = ready;
        ov[k] = overrun;
        tx[k] = dataTx;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset  = 1'b1;
        start  = 1'b0;
        data   = '0;
        chMask = '0;
        gap    = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Pulse / one-hot sanity over captured cycles 0..n-1.
    task automatic check_invariants(input string name, input int n);
        int bad;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            if ($countones(ex[k]) > 1 || (ex[k] != '0 && dr[k])) bad++;
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL %s_invariants: violations=%0d expected=0", name, bad);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; data = '0; chMask = '0; gap = '0;
        @(posedge clk); #1;
        @(negedge clk);
        total_cnt++;
        if (ready !== 1'b0) $display("FAIL reset_ready_low: got=%b expected=0", ready);
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({ready, busy, dataReady, overrun, execute} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'b0000})
            $display("FAIL reset_outputs: got rdy=%b busy=%b dr=%b ov=%b ex=%b expected 1 0 0 0 0000",
                     ready, busy, dataReady, overrun, execute);
        else pass_cnt++;
        total_cnt++;
        if (dataTx !== '0) $display("FAIL reset_dataTx: got=%h expected=0", dataTx);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_gap0();
        logic [NUM_CH-1:0] exp_ex;
        int bad;
        apply_reset();
        chMask = 4'b0011; gap = 0; data = 8'hA5; start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            sample(k);
            next_cycle();
            start = 1'b0;
        end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            exp_ex = (k == 3) ? 4'b0001 : (k == 4) ? 4'b0010 : 4'b0000;
            if (ex[k] !== exp_ex) begin
                bad++;
                $display("FAIL basic_execute_c%0d: got=%b expected=%b", k, ex[k], exp_ex);
            end
            if (dr[k] !== (k == 5)) begin
                bad++;
                $display("FAIL basic_dataReady_c%0d: got=%b expected=%b", k, dr[k], (k == 5));
            end
        end
        total_cnt++;
        if (bad == 0) pass_cnt++;
        total_cnt++;
        if (tx[3] !== 32'h0000_00A5) $display("FAIL basic_lane0_c3: got=%h expected=000000a5", tx[3]);
        else pass_cnt++;
        total_cnt++;
        if (tx[4] !== 32'h0000_A5A5) $display("FAIL basic_lanes_c4: got=%h expected=0000a5a5", tx[4]);
        else pass_cnt++;
        total_cnt++;
        if (bz[5] !== 1'b1 || bz[6] !== 1'b0)
            $display("FAIL basic_busy: got c5=%b c6=%b expected 1 0", bz[5], bz[6]);
        else pass_cnt++;
        check_invariants("basic", 10);
    endtask

    task automatic test_mask_gap2();
        logic [NUM_CH-1:0] exp_ex;
        int bad;
        apply_reset();
        chMask = 4'b1010; gap = 2; data = 8'h3C; start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            sample(k);
            next_cycle();
            start = 1'b0;
        end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            exp_ex = (k == 3) ? 4'b0010 : (k == 6) ? 4'b1000 : 4'b0000;
            if (ex[k] !== exp_ex) begin
                bad++;
                $display("FAIL gap2_execute_c%0d: got=%b expected=%b", k, ex[k], exp_ex);
            end
        end
        total_cnt++;
        if (bad == 0) pass_cnt++;
        total_cnt++;
        if (dr[7] !== 1'b1 || dr[6] !== 1'b0 || dr[8] !== 1'b0)
            $display("FAIL gap2_dataReady: got c6=%b c7=%b c8=%b expected 0 1 0", dr[6], dr[7], dr[8]);
        else pass_cnt++;
        total_cnt++;
        if (tx[7] !== 32'h3C00_3C00) $display("FAIL gap2_lanes: got=%h expected=3c003c00", tx[7]);
        else pass_cnt++;
        check_invariants("gap2", 10);
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] seen [$];
        int n_dr;
        int bad;
        apply_reset();
        chMask = 4'b0011; gap = 0;
        for (int k = 0; k < 20; k++) begin
            start = (k < 4);
            data  = DATA_W'(k + 1);
            sample(k);
            next_cycle();
        end
        start = 1'b0;
        total_cnt++;
        if ({rd[0], rd[1], rd[2], rd[3]} !== 4'b1101)
            $display("FAIL b2b_ready: got c0..c3=%b%b%b%b expected=1101", rd[0], rd[1], rd[2], rd[3]);
        else pass_cnt++;
        total_cnt++;
        if (ov[2] !== 1'b0 || ov[3] !== 1'b1 || ov[19] !== 1'b1)
            $display("FAIL b2b_overrun: got c2=%b c3=%b c19=%b expected 0 1 1", ov[2], ov[3], ov[19]);
        else pass_cnt++;
        n_dr = 0;
        bad  = 0;
        for (int k = 0; k < 20; k++) begin
            if (dr[k]) n_dr++;
            if (dr[k] !== ((k == 5) || (k == 9) || (k == 13))) bad++;
            if (ex[k][0]) seen.push_back(tx[k][7:0]);
        end
        total_cnt++;
        if (n_dr != 3 || bad != 0)
            $display("FAIL b2b_dataReady: got pulses=%0d misplaced=%0d expected 3 at c5,c9,c13", n_dr, bad);
        else pass_cnt++;
        total_cnt++;
        if (seen.size() != 3) begin
            $display("FAIL b2b_order: got %0d lane0 fires expected=3", seen.size());
        end else if (seen[0] !== 8'd1 || seen[1] !== 8'd2 || seen[2] !== 8'd4) begin
            $display("FAIL b2b_order: got %0d,%0d,%0d expected 1,2,4", seen[0], seen[1], seen[2]);
        end else pass_cnt++;
        check_invariants("b2b", 20);
    endtask

    task automatic test_empty_mask();
        int bad;
        apply_reset();
        chMask = 4'b0000; gap = 0; data = 8'h77; start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            sample(k);
            next_cycle();
            start = 1'b0;
        end
        bad = 0;
        for (int k = 0; k < 6; k++) if (ex[k] !== 4'b0000) bad++;
        total_cnt++;
        if (bad != 0) $display("FAIL nomask_execute: got %0d cycles with execute expected=0", bad);
        else pass_cnt++;
        total_cnt++;
        if (dr[3] !== 1'b1 || dr[2] !== 1'b0 || dr[4] !== 1'b0)
            $display("FAIL nomask_dataReady: got c2=%b c3=%b c4=%b expected 0 1 0", dr[2], dr[3], dr[4]);
        else pass_cnt++;
        total_cnt++;
        if (bz[3] !== 1'b1 || bz[4] !== 1'b0)
            $display("FAIL nomask_busy: got c3=%b c4=%b expected 1 0", bz[3], bz[4]);
        else pass_cnt++;
    endtask

    task automatic test_mask_sampling();
        logic [NUM_CH-1:0] exp_ex;
        int bad;
        apply_reset();
        chMask = 4'b0011; gap = 5; data = 8'hC3; start = 1'b1;
        for (int k = 0; k < 12; k++) begin
            sample(k);
            next_cycle();
            start = 1'b0;
            if (k + 1 >= 4) chMask = 4'b0000;
        end
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            exp_ex = (k == 3) ? 4'b0001 : (k == 9) ? 4'b0010 : 4'b0000;
            if (ex[k] !== exp_ex) begin
                bad++;
                $display("FAIL sampling_execute_c%0d: got=%b expected=%b", k, ex[k], exp_ex);
            end
        end
        total_cnt++;
        if (bad == 0) pass_cnt++;
        total_cnt++;
        if (dr[10] !== 1'b1 || tx[9][15:8] !== 8'hC3)
            $display("FAIL sampling_done: got dr_c10=%b lane1=%h expected 1 c3", dr[10], tx[9][15:8]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_gap();
        int bad;
        apply_reset();
        chMask = 4'b0011; gap = 8; data = 8'h5A; start = 1'b1;
        for (int k = 0; k < 26; k++) begin
            sample(k);
            next_cycle();
            start = 1'b0;
            reset = (k + 1 == 6) || (k + 1 == 7);
        end
        reset = 1'b0;
        total_cnt++;
        if (ex[3] !== 4'b0001 || tx[5] !== 32'h0000_005A)
            $display("FAIL abort_prefire: got ex_c3=%b tx_c5=%h expected 0001 0000005a", ex[3], tx[5]);
        else pass_cnt++;
        total_cnt++;
        if (ex[7] !== 4'b0000 || tx[7] !== '0 || rd[7] !== 1'b0)
            $display("FAIL abort_cleared: got ex=%b tx=%h rdy=%b expected 0000 0 0", ex[7], tx[7], rd[7]);
        else pass_cnt++;
        total_cnt++;
        if (rd[8] !== 1'b1 || bz[8] !== 1'b0)
            $display("FAIL abort_idle: got rdy=%b busy=%b expected 1 0", rd[8], bz[8]);
        else pass_cnt++;
        bad = 0;
        for (int k = 4; k < 26; k++) if (dr[k] || ex[k] != '0) bad++;
        total_cnt++;
        if (bad != 0) $display("FAIL abort_no_dispatch: got %0d active cycles expected=0", bad);
        else pass_cnt++;
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        data   = '0;
        chMask = '0;
        gap    = '0;
        test_reset();
        test_basic_gap0();
        test_mask_gap2();
        test_back_to_back();
        test_empty_mask();
        test_mask_sampling();
        test_reset_mid_gap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/timing_engine_fanout.md
Name: timing_engine_fanout

Overview:
- Parametrised successor of the two-stage timing-engine bus.
- Accepts start/data requests through a DEPTH-entry request FIFO and reports acceptance via ready.
- Dispatches each request to NUM_CH execute/dataTx channel pairs, in ascending channel order, with a programmable inter-channel gap and per-request channel mask.
- Pulses dataReady when a request has been dispatched to all enabled channels; sits between the request source and the per-channel execution stages.

Parameters:
- NUM_CH, 2, number of execute/dataTx channels (1..16)
- DATA_W, 1, width of data and of each dataTx lane
- DEPTH, 2, request FIFO entries (power of 2, >=2)
- GAP_W, 4, width of gap input

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request strobe; accepted when start && ready
- data  in  DATA_W  request payload, sampled with start
- chMask  in  NUM_CH  channel enable mask, sampled in LOAD
- gap  in  GAP_W  idle cycles between consecutive channel fires, sampled at each FIRE
- ready  out  1  FIFO can accept a request
- dataReady  out  1  one-cycle pulse: current request fully dispatched
- execute  out  NUM_CH  one-hot, one-cycle fire pulse per channel
- dataTx  out  NUM_CH*DATA_W  per-channel payload; lane i = bits [i*DATA_W +: DATA_W]
- busy  out  1  FSM not IDLE or FIFO non-empty
- overrun  out  1  sticky: a start was dropped

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - ready=0 while reset is high; dataReady=0, execute=0, dataTx=0, busy=0, overrun=0.
  - FIFO is emptied and the FSM returns to IDLE.
  - Reset mid-operation aborts the current and all queued requests; no dataReady is issued for them.
- ready: equals !full (count<DEPTH) when not in reset; combinational from the registered count.
  - A pop in the same cycle does not free a slot for that cycle's start.
- Accept: start && ready pushes data.
  - start && !ready drops the request and sets overrun, which is cleared only by reset.
- FSM states: IDLE, LOAD, FIRE, GAP, DONE.
  - IDLE: if FIFO non-empty -> LOAD.
  - LOAD: pop head into curData; pend <= chMask.
    - pend==0 -> DONE.
    - Otherwise -> FIRE.
  - FIRE: i = lowest set bit of pend.
    - execute[i]=1 for this cycle only; dataTx lane i <= curData, visible in the same cycle as execute[i], held until that lane next fires.
    - Clear pend[i].
    - If remaining pend==0 -> DONE.
    - Else if gap==0 -> FIRE (back-to-back).
    - Else load cnt=gap -> GAP.
  - GAP: decrement cnt; when cnt reaches 1 -> FIRE, so exactly gap idle cycles occur between fires.
  - DONE: dataReady=1 for one cycle; FIFO non-empty -> LOAD, else IDLE.
- Latency, with start high in cycle 0 and the block idle and empty:
  - IDLE in cycle 1, LOAD in cycle 2, first FIRE in cycle 3.
  - k-th enabled channel fires at cycle 3+(k-1)*(gap+1), using gap held constant.
  - dataReady fires the cycle after the last FIRE.
- Sampling points:
  - chMask changes after LOAD do not affect the in-flight request.
  - gap is sampled at each FIRE that continues to GAP.
- FIFO pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
  - Simultaneous push (count<DEPTH) and pop leaves count unchanged.
- Only one execute bit may be high in any cycle; execute and dataReady are never high together.

Test Plan:
- NUM_CH=2, DATA_W=8, chMask=2'b11, gap=0; start with data=0xA5 in cycle 0 -> execute=2'b01 in cycle 3, 2'b10 in cycle 4; both dataTx lanes=0xA5; dataReady in cycle 5; busy low from cycle 6.
- NUM_CH=4, chMask=4'b1010, gap=2 -> execute[1] in cycle 3, execute[3] in cycle 6, none in cycles 4-5; dataReady in cycle 7; lanes 0 and 2 remain 0.
- DEPTH=2, gap=0, chMask=2'b11; start high in cycles 0-3 with data 1,2,3,4 -> ready=0 in cycle 2; data 3 dropped and overrun=1 from cycle 3; data 1, 2 and 4 dispatched in order with three dataReady pulses; overrun stays 1.
- chMask=0; start in cycle 0 -> no execute; dataReady in cycle 3; busy low in cycle 4.
- chMask=2'b11, gap=5; after the first FIRE, change chMask to 0 -> the second channel still fires at cycle 9.
- gap=8; assert reset during GAP -> next cycle execute=0, dataTx=0, ready=0; after reset, ready=1, busy=0, and no dataReady is ever seen for the aborted request.
